ikaopll_bus_sequencer: RTL

- Host-side write scheduler for the IKAOPLL core. Accepts register writes (address, data) from a valid/ready requester and buffers them in a small FIFO.
- Replays the writes onto the core's chip bus (IC_n, CS_n, WR_n, A0, D) with YM2413-legal pulse widths and inter-write wait times.
- Generates the chip reset pulse after system reset.
- Sits between a CPU/soft-core and the core's bus pins; all bus timing is counted in phiM enable ticks.

---
 rtl/ikaopll_bus_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/ikaopll_bus_sequencer.sv
// rtl/ikaopll_bus_sequencer.sv - buffers host register writes and replays them on the IKAOPLL chip bus
// All bus timing is counted in phiM enable ticks; every timed state lasts exactly N ticks.
module ikaopll_bus_sequencer #(
  parameter int FIFO_AW     = 2,
  parameter int IC_TICKS    = 80,
  parameter int WR_TICKS    = 4,
  parameter int AWAIT_TICKS = 12,
  parameter int DWAIT_TICKS = 84,
  parameter int ADDR_SKIP   = 1
) (
  input  logic               i_EMUCLK,
  input  logic               i_RST_n,
  input  logic               i_phiM_PCEN_n,
  input  logic               i_WRQ_VALID,
  output logic               o_WRQ_READY,
  input  logic [7:0]         i_WRQ_ADDR,
  input  logic [7:0]         i_WRQ_DATA,
  output logic [FIFO_AW:0]   o_FIFO_LEVEL,
  output logic               o_BUSY,
  output logic               o_IC_n,
  output logic               o_CS_n,
  output logic               o_WR_n,
  output logic               o_A0,
  output logic [7:0]         o_D
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L  = (FIFO_AW+1)'(DEPTH);
  localparam logic [7:0]       IC_M1    = 8'(IC_TICKS - 1);
  localparam logic [7:0]       WR_M1    = 8'(WR_TICKS - 1);
  localparam logic [7:0]       AWAIT_M1 = 8'(AWAIT_TICKS - 1);
  localparam logic [7:0]       DWAIT_M1 = 8'(DWAIT_TICKS - 1);

  typedef enum logic [2:0] {RST_IC, IDLE, AWR, AWAIT, DWR, DWAIT} state_t;

  state_t             state, state_nx;
  logic [7:0]         cnt, cnt_nx;
  logic [7:0]         waddr, wdata, last_addr;
  logic               last_vld;
  logic [7:0]         fifo_addr [DEPTH];
  logic [7:0]         fifo_data [DEPTH];
  logic [FIFO_AW-1:0] wptr, rptr;
  logic [FIFO_AW:0]   level_nx;
  logic               tick, done, push, pop, skip;

  assign tick     = ~i_phiM_PCEN_n;
  assign done     = tick && (cnt == 8'd0);
  assign push     = i_WRQ_VALID && o_WRQ_READY;
  assign pop      = (state == IDLE) && (o_FIFO_LEVEL != '0);
  assign skip     = (ADDR_SKIP != 0) && last_vld && (fifo_addr[rptr] == last_addr);
  assign level_nx = o_FIFO_LEVEL + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (tick && (cnt != 8'd0)) cnt_nx = cnt - 8'd1;
    case (state)
      RST_IC: if (done) state_nx = IDLE;
      IDLE: begin
        if (pop) begin
          state_nx = skip ? DWR : AWR;
          cnt_nx   = WR_M1;
        end
      end
      AWR: begin
        if (done) begin
          state_nx = AWAIT;
          cnt_nx   = AWAIT_M1;
        end
      end
      AWAIT: begin
        if (done) begin
          state_nx = DWR;
          cnt_nx   = WR_M1;
        end
      end
      DWR: begin
        if (done) begin
          state_nx = DWAIT;
          cnt_nx   = DWAIT_M1;
        end
      end
      DWAIT: if (done) state_nx = IDLE;
      default: begin
        state_nx = RST_IC;
        cnt_nx   = IC_M1;
      end
    endcase
  end

  // FIFO storage needs no reset: the level and pointers define which entries are live.
  always_ff @(posedge i_EMUCLK) begin
    if (push) begin
      fifo_addr[wptr] <= i_WRQ_ADDR;
      fifo_data[wptr] <= i_WRQ_DATA;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state        <= RST_IC;
      cnt          <= IC_M1;
      o_IC_n       <= 1'b0;
      o_CS_n       <= 1'b1;
      o_WR_n       <= 1'b1;
      o_A0         <= 1'b0;
      o_D          <= 8'h00;
      o_WRQ_READY  <= 1'b0;
      o_FIFO_LEVEL <= '0;
      o_BUSY       <= 1'b1;
      wptr         <= '0;
      rptr         <= '0;
      waddr        <= 8'h00;
      wdata        <= 8'h00;
      last_addr    <= 8'h00;
      last_vld     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      o_IC_n       <= (state_nx != RST_IC);
      o_CS_n       <= !((state_nx == AWR) || (state_nx == DWR));
      o_WR_n       <= !((state_nx == AWR) || (state_nx == DWR));
      // Ready opens one clock after the chip reset pulse ends.
      o_WRQ_READY  <= (state != RST_IC) && (level_nx < DEPTH_L);
      o_FIFO_LEVEL <= level_nx;
      o_BUSY       <= (state_nx != IDLE) || (level_nx != '0);
      if (push) wptr <= wptr + FIFO_AW'(1);
      if (pop) begin
        rptr  <= rptr + FIFO_AW'(1);
        waddr <= fifo_addr[rptr];
        wdata <= fifo_data[rptr];
        o_A0  <= skip;
        o_D   <= skip ? fifo_data[rptr] : fifo_addr[rptr];
      end
      if ((state == AWAIT) && done) begin
        o_A0 <= 1'b1;
        o_D  <= wdata;
      end
      if ((state == AWR) && done) begin
        last_addr <= waddr;
        last_vld  <= 1'b1;
      end
    end
  end
endmodule
